// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and the
// bundle of pipeline-register control pins it drives each cycle.
package pipe_hazard_ctl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic pc_src;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_flush;
        logic dmem_req;
    } ctl_t;

    // Free-running pipe: everything advances, nothing squashed.
    localparam ctl_t CTL_RUN = '{
        pc_en: 1'b1, pc_src: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b0,
        idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1, memwb_flush: 1'b0,
        dmem_req: 1'b0
    };

    localparam ctl_t CTL_RESET = '{
        pc_en: 1'b0, pc_src: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
        idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0, memwb_flush: 1'b1,
        dmem_req: 1'b0
    };

    // Hold every stage and push a bubble into MEM/WB while memory is busy.
    function automatic ctl_t ctl_freeze(input ctl_t c);
        ctl_t r;
        r             = c;
        r.pc_en       = 1'b0;
        r.ifid_en     = 1'b0;
        r.idex_en     = 1'b0;
        r.exmem_en    = 1'b0;
        r.memwb_flush = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register 0 is hard-wired and never a hazard.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_idex_memread,
    input  logic [REG_W-1:0] i_idex_rt,
    output logic             o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit   = (i_idex_rt == i_id_rs);
    assign w_rt_hit   = (i_idex_rt == i_id_rt);
    assign o_load_use = i_idex_memread && (i_idex_rt != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencer for the 5-stage datapath: load-use bubbles, taken-branch
// squash, data-memory handshake with timeout, and stall/flush counters.
module pipe_hazard_ctl
    import pipe_hazard_ctl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             pc_src,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_next;
    logic               r_mem_err;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    ctl_t               w_ctl;
    logic               w_load_use;
    logic               w_mem_op;
    logic               w_taken;
    logic               w_advance;
    logic               w_timeout;
    logic               w_flush_inc;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .o_load_use     (w_load_use)
    );

    assign w_mem_op = exmem_memread | exmem_memwrite;
    assign w_taken  = exmem_branch & exmem_zero;

    always_comb begin
        // NOTE: every output of this block is defaulted up front so no path
        // through the case leaves one unassigned and infers a latch.
        w_ctl        = CTL_RUN;
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        w_advance    = 1'b0;
        w_timeout    = 1'b0;
        w_flush_inc  = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                w_ctl.dmem_req = w_mem_op;
                if (w_mem_op && !dmem_ack) begin
                    w_ctl        = ctl_freeze(w_ctl);
                    w_state_next = ST_MEM_WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                w_ctl.dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_wait_next = '0;
                    w_advance   = 1'b1;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // Abandon the access: let the stuck op drain as a bubble.
                    w_ctl.dmem_req    = 1'b0;
                    w_ctl.memwb_flush = 1'b1;
                    w_timeout         = 1'b1;
                    w_wait_next       = '0;
                    w_state_next      = ST_RUN;
                end else begin
                    w_ctl       = ctl_freeze(w_ctl);
                    w_wait_next = r_wait_cnt + WAIT_W'(1);
                end
            end
            ST_FLUSH: begin
                w_ctl.idex_flush = 1'b1;
                w_state_next     = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // A cycle where memory is not holding the pipe resolves branch, then load-use.
        if (w_advance) begin
            w_state_next = ST_RUN;
            if (w_taken) begin
                w_ctl.pc_src     = 1'b1;
                w_ctl.ifid_flush = 1'b1;
                w_ctl.idex_flush = 1'b1;
                w_flush_inc      = 1'b1;
                w_state_next     = ST_FLUSH;
            end else if (w_load_use) begin
                w_ctl.pc_en      = 1'b0;
                w_ctl.ifid_en    = 1'b0;
                w_ctl.idex_flush = 1'b1;
            end
        end

        if (rst) begin
            w_ctl = CTL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            if (!w_ctl.pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en       = w_ctl.pc_en;
    assign pc_src      = w_ctl.pc_src;
    assign ifid_en     = w_ctl.ifid_en;
    assign ifid_flush  = w_ctl.ifid_flush;
    assign idex_en     = w_ctl.idex_en;
    assign idex_flush  = w_ctl.idex_flush;
    assign exmem_en    = w_ctl.exmem_en;
    assign memwb_flush = w_ctl.memwb_flush;
    assign dmem_req    = w_ctl.dmem_req;
    assign mem_err     = r_mem_err;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: a cycle-level behavioural model checked
// on every falling edge, plus hand-computed expectations per scenario.
module tb_pipe_hazard_ctl;

    localparam int REG_W       = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, idex_rt;
    logic             idex_memread, exmem_branch, exmem_zero;
    logic             exmem_memread, exmem_memwrite, dmem_ack;
    logic             pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_en, memwb_flush, dmem_req, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(
        .REG_W       (REG_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .exmem_branch   (exmem_branch),
        .exmem_zero     (exmem_zero),
        .exmem_memread  (exmem_memread),
        .exmem_memwrite (exmem_memwrite),
        .dmem_ack       (dmem_ack),
        .pc_en          (pc_en),
        .pc_src         (pc_src),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .memwb_flush    (memwb_flush),
        .dmem_req       (dmem_req),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model state: m_age < 0 means no access outstanding, otherwise the number
    // of wait cycles already spent; m_squash marks the cycle after a redirect.
    int m_age = -1, n_age = -1;
    bit m_squash = 1'b0, n_squash = 1'b0;
    bit m_err = 1'b0, n_err = 1'b0;
    int m_stalls = 0, n_stalls = 0;
    int m_flushes = 0, n_flushes = 0;

    always @(negedge clk) begin : compare
        bit mem_op, taken, hazard, proceed;
        bit e_pc_en, e_pc_src, e_ifid_en, e_ifid_flush, e_idex_en;
        bit e_idex_flush, e_exmem_en, e_memwb_flush, e_req;

        mem_op  = exmem_memread | exmem_memwrite;
        taken   = exmem_branch & exmem_zero;
        hazard  = idex_memread && (idex_rt != 0) && (idex_rt == id_rs || idex_rt == id_rt);
        proceed = 1'b0;
        {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = 4'b1111;
        {e_pc_src, e_ifid_flush, e_idex_flush, e_memwb_flush, e_req} = 5'b00000;
        n_age = m_age; n_squash = 1'b0; n_err = m_err;
        n_stalls = m_stalls; n_flushes = m_flushes;

        if (rst) begin
            {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = 4'b0000;
            {e_ifid_flush, e_idex_flush, e_memwb_flush} = 3'b111;
            n_age = -1; n_err = 1'b0; n_stalls = 0; n_flushes = 0;
        end else begin
            if (m_squash) begin
                e_idex_flush = 1'b1;
            end else if (m_age >= 0) begin
                e_req = 1'b1;
                if (dmem_ack) begin
                    proceed = 1'b1;
                    n_age   = -1;
                end else if (m_age + 1 == MEM_TIMEOUT) begin
                    e_req = 1'b0; e_memwb_flush = 1'b1; n_err = 1'b1; n_age = -1;
                end else begin
                    {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = 4'b0000;
                    e_memwb_flush = 1'b1;
                    n_age = m_age + 1;
                end
            end else begin
                e_req = mem_op;
                if (mem_op && !dmem_ack) begin
                    {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = 4'b0000;
                    e_memwb_flush = 1'b1;
                    n_age = 0;
                end else begin
                    proceed = 1'b1;
                end
            end
            if (proceed && taken) begin
                e_pc_src = 1'b1; e_ifid_flush = 1'b1; e_idex_flush = 1'b1;
                n_squash = 1'b1;
                n_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : m_flushes;
            end else if (proceed && hazard) begin
                e_pc_en = 1'b0; e_ifid_en = 1'b0; e_idex_flush = 1'b1;
            end
            if (!e_pc_en) n_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : m_stalls;
        end

        check("ctl{pc_en,pc_src,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,memwb_fl,req}",
              {pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, dmem_req},
              {e_pc_en, e_pc_src, e_ifid_en, e_ifid_flush, e_idex_en, e_idex_flush, e_exmem_en, e_memwb_flush, e_req});
        check("stall_cnt", stall_cnt, m_stalls);
        check("flush_cnt", flush_cnt, m_flushes);
        check("mem_err", mem_err, m_err);
    end

    always @(posedge clk) begin
        m_age     <= n_age;
        m_squash  <= n_squash;
        m_err     <= n_err;
        m_stalls  <= n_stalls;
        m_flushes <= n_flushes;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; idex_rt = '0; idex_memread = 1'b0;
        exmem_branch = 1'b0; exmem_zero = 1'b0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0; dmem_ack = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_pc_en", pc_en, 0);
        check("rst_ifid_en", ifid_en, 0);
        check("rst_idex_flush", idex_flush, 1);
        check("rst_memwb_flush", memwb_flush, 1);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("idle_pc_en", pc_en, 1);
        check("idle_idex_flush", idex_flush, 0);

        // Load-use through rs
        tick(); id_rs = 5; idex_memread = 1'b1; idex_rt = 5;
        @(negedge clk);
        check("lu_pc_en", pc_en, 0);
        check("lu_ifid_en", ifid_en, 0);
        check("lu_idex_flush", idex_flush, 1);
        check("lu_idex_en", idex_en, 1);
        tick(); idle();
        @(negedge clk);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_release", pc_en, 1);

        // r0 never hazards; rt path hazards; non-load never hazards
        tick(); idex_memread = 1'b1;
        @(negedge clk);
        check("r0_pc_en", pc_en, 1);
        check("r0_idex_flush", idex_flush, 0);
        tick(); id_rs = 1; id_rt = 9; idex_rt = 9; idex_memread = 1'b1;
        @(negedge clk);
        check("lu_rt_pc_en", pc_en, 0);
        tick(); idex_memread = 1'b0;
        @(negedge clk);
        check("noload_pc_en", pc_en, 1);
        check("noload_stall_cnt", stall_cnt, 2);

        // Branch not taken, then taken
        tick(); idle(); exmem_branch = 1'b1;
        @(negedge clk);
        check("nt_pc_src", pc_src, 0);
        tick(); exmem_zero = 1'b1;
        @(negedge clk);
        check("tk_pc_src", pc_src, 1);
        check("tk_ifid_flush", ifid_flush, 1);
        check("tk_idex_flush", idex_flush, 1);
        check("tk_pc_en", pc_en, 1);
        tick(); idle();
        @(negedge clk);
        check("fl_idex_flush", idex_flush, 1);
        check("fl_ifid_flush", ifid_flush, 0);
        check("fl_pc_src", pc_src, 0);
        check("fl_flush_cnt", flush_cnt, 1);
        tick();
        @(negedge clk);
        check("fl_done", idex_flush, 0);

        // Clear counters, then a load acked on the fourth request cycle
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; exmem_memread = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            @(negedge clk);
            check("ack_req", dmem_req, 1);
            check("ack_pc_en", pc_en, (i == 3));
            check("ack_exmem_en", exmem_en, (i == 3));
            tick();
        end
        idle();
        @(negedge clk);
        check("ack_req_drop", dmem_req, 0);
        check("ack_stall_cnt", stall_cnt, 3);

        // Store never acked: timeout on the fourth wait cycle
        tick(); exmem_memwrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("to_req", dmem_req, (i < 4));
            check("to_pc_en", pc_en, (i == 4));
            check("to_memwb_flush", memwb_flush, 1);
            check("to_mem_err_pre", mem_err, 0);
            tick();
        end
        idle();
        @(negedge clk);
        check("to_mem_err", mem_err, 1);
        check("to_req_after", dmem_req, 0);
        check("to_resume", pc_en, 1);
        check("to_stall_cnt", stall_cnt, 7);

        // Stall counter saturates at all-ones
        tick(); id_rs = 4; idex_rt = 4; idex_memread = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("sat_stall_cnt", stall_cnt, 7);

        // Reset while waiting on memory
        tick(); idle(); exmem_memread = 1'b1;
        @(negedge clk);
        check("rw_req_issue", dmem_req, 1);
        tick();
        @(negedge clk);
        check("rw_req_wait", dmem_req, 1);
        tick(); rst = 1'b1;
        @(negedge clk);
        check("rw_req_in_rst", dmem_req, 0);
        tick(); rst = 1'b0; exmem_memread = 1'b0;
        @(negedge clk);
        check("rw_req", dmem_req, 0);
        check("rw_mem_err", mem_err, 0);
        check("rw_stall_cnt", stall_cnt, 0);
        check("rw_flush_cnt", flush_cnt, 0);
        check("rw_pc_en", pc_en, 1);

        // Load-use and taken branch together: branch wins; FLUSH ignores load-use
        tick(); id_rs = 3; idex_rt = 3; idex_memread = 1'b1;
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        @(negedge clk);
        check("both_pc_src", pc_src, 1);
        check("both_pc_en", pc_en, 1);
        check("both_ifid_flush", ifid_flush, 1);
        tick(); exmem_branch = 1'b0; exmem_zero = 1'b0;
        @(negedge clk);
        check("both_fl_pc_en", pc_en, 1);
        check("both_fl_idex_flush", idex_flush, 1);
        check("both_flush_cnt", flush_cnt, 1);
        check("both_stall_cnt", stall_cnt, 0);
        tick();
        @(negedge clk);
        check("both_lu_after", pc_en, 0);

        // Memory wait outranks a branch; branch applies on the ack cycle
        tick(); idle(); exmem_memread = 1'b1; exmem_branch = 1'b1; exmem_zero = 1'b1;
        @(negedge clk);
        check("mb_pc_src_hold", pc_src, 0);
        check("mb_pc_en_hold", pc_en, 0);
        tick(); dmem_ack = 1'b1;
        @(negedge clk);
        check("mb_pc_src_ack", pc_src, 1);
        check("mb_req_ack", dmem_req, 1);
        check("mb_pc_en_ack", pc_en, 1);
        tick(); idle();
        @(negedge clk);
        check("mb_fl_idex_flush", idex_flush, 1);
        check("mb_flush_cnt", flush_cnt, 2);

        tick(); tick();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
